// File: rtl/dm_access_ctrl.sv
// Load/store sequencer between the MEM stage and a req/ack data memory.
// Optional bus timeout abort enabled by defining DM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a new access (req_ready=1)
// BUSY  | memory request outstanding, waiting for mem_ack
// RESP  | one-cycle completion pulse on resp_valid
module dm_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic        we_q;
  logic [2:0]  op_q;
  logic [1:0]  lo_q;

  logic        acc_mis;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        timeout_hit;

  if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

`ifdef DM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Decode of the incoming request; undefined ops behave as word accesses.
  always_comb begin
    acc_be    = 4'b1111;
    acc_wdata = req_wdata;
    acc_mis   = (req_addr[1:0] != 2'b00);
    case (req_op)
      3'b001, 3'b010: begin
        acc_be    = 4'b0001 << req_addr[1:0];
        acc_wdata = {4{req_wdata[7:0]}};
        acc_mis   = 1'b0;
      end
      3'b011, 3'b100: begin
        acc_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{req_wdata[15:0]}};
        acc_mis   = req_addr[0];
      end
      default: ;
    endcase
    if (!req_we) acc_wdata = '0;
  end

  always_comb begin
    ld_byte = mem_rdata[{lo_q, 3'b000} +: 8];
    ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      3'b001:  ld_data = {24'b0, ld_byte};
      3'b010:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b011:  ld_data = {16'b0, ld_half};
      3'b100:  ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
    if (we_q) ld_data = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      we_q       <= 1'b0;
      op_q       <= '0;
      lo_q       <= '0;
`ifdef DM_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            op_q      <= req_op;
            lo_q      <= req_addr[1:0];
            req_ready <= 1'b0;
            if (acc_mis) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 2'b01;
              resp_rdata <= '0;
            end else begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= acc_be;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= acc_wdata;
`ifdef DM_TIMEOUT_EN
              cnt       <= '0;
`endif
            end
          end
        end
        BUSY: begin
          // An ack in the limit cycle takes priority over the timeout.
          if (mem_ack || timeout_hit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if (mem_ack) begin
              resp_rdata <= ld_data;
              resp_err   <= 2'b00;
            end else begin
              resp_rdata <= '0;
              resp_err   <= 2'b10;
            end
          end
`ifdef DM_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: transaction-level model drives a
// cycle timeline of expected outputs that a negedge compare process checks.
`timescale 1ns/1ps
module tb_dm_access_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dm_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  logic        e_ready, e_rv, e_mreq, e_mwe;
  logic [3:0]  e_mbe;
  logic [31:0] e_maddr, e_mwd, e_rdata;
  logic [1:0]  e_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        chk("mem_req", 32'(mem_req), 32'(e_mreq));
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_err", 32'(resp_err), 32'(e_err));
        if (e_mreq) begin
          chk("mem_we", 32'(mem_we), 32'(e_mwe));
          chk("mem_be", 32'(mem_be), 32'(e_mbe));
          chk("mem_addr", mem_addr, e_maddr);
          chk("mem_wdata", mem_wdata, e_mwd);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req(input bit v);
    req_valid = v;
    req_we    = 1'($urandom);
    req_op    = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic idle();
    e_ready = 1'b1; e_rv = 1'b0; e_mreq = 1'b0;
    rand_req(1'b0);
    mem_ack   = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  // One access, starting in an IDLE cycle and ending in the following IDLE cycle.
  task automatic access(input bit we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int wait_n,
                        input bit lit, input logic [3:0] lit_be, input logic [31:0] lit_wd,
                        input logic [31:0] lit_rd);
    int size, nb, sh;
    bit mis, to_hit;
    logic [31:0] be_w, wd, rd, mask, lane;
    logic [1:0] err;
    size = (op == 3'd1 || op == 3'd2) ? 1 : (op == 3'd3 || op == 3'd4) ? 2 : 4;
    mis  = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
    sh   = 8 * int'(addr[1:0]);
    be_w = ((32'd1 << size) - 32'd1) << addr[1:0];
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (!we)            wd = 32'd0;
    else if (size == 1) wd = {24'd0, wdata[7:0]} * 32'h0101_0101;
    else if (size == 2) wd = {16'd0, wdata[15:0]} * 32'h0001_0001;
    else                wd = wdata;
    lane = (rdata >> sh) & mask;
    if ((op == 3'd2 || op == 3'd4) && lane[8*size-1]) lane = lane | ~mask;
    to_hit = 1'b0;
`ifdef DM_TIMEOUT_EN
    to_hit = (wait_n >= TO);
`endif
    nb  = to_hit ? TO : wait_n + 1;
    rd  = (we || to_hit) ? 32'd0 : lane;
    err = to_hit ? 2'b10 : 2'b00;

    idle();
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    step();
    if (mis) begin
      rand_req(1'($urandom));
      mem_ack = 1'($urandom);
      e_ready = 1'b0; e_rv = 1'b1; e_mreq = 1'b0; e_rdata = 32'd0; e_err = 2'b01;
      step();
    end else begin
      for (int i = 0; i < nb; i++) begin
        rand_req(1'($urandom));
        e_ready = 1'b0; e_rv = 1'b0; e_mreq = 1'b1; e_mwe = we; e_mbe = be_w[3:0];
        e_maddr = {addr[31:2], 2'b00}; e_mwd = wd;
        mem_ack   = !to_hit && (i == wait_n);
        mem_rdata = mem_ack ? rdata : $urandom;
        if (lit && i == 0) begin
          chk("lit_mem_be", 32'(mem_be), 32'(lit_be));
          chk("lit_mem_wdata", mem_wdata, lit_wd);
        end
        step();
      end
      rand_req(1'($urandom));
      mem_ack = 1'($urandom);
      e_ready = 1'b0; e_rv = 1'b1; e_mreq = 1'b0; e_rdata = rd; e_err = err;
      if (lit) chk("lit_resp_rdata", resp_rdata, lit_rd);
      step();
    end
    idle();
  endtask

  logic        r_we;
  logic [2:0]  r_op;
  logic [31:0] r_addr, r_wd, r_rd;

  initial begin
    reset = 1'b0;
    idle();
    mem_ack = 1'b0;
    e_mwe = 1'b0; e_mbe = '0; e_maddr = '0; e_mwd = '0; e_rdata = '0; e_err = 2'b00;
    cmp_en = 1'b1;
    repeat (3) step();
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    reset = 1'b1;
    step();
    idle();

    // lb, lhu with 3 wait cycles, sb, misaligned lw and sh
    access(1'b0, 3'b010, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b1, 4'b1000, 32'h0, 32'hFFFF_FF80);
    access(1'b0, 3'b011, 32'h0000_0042, 32'h0, 32'hBEEF_0000, 3, 1'b1, 4'b1100, 32'h0, 32'h0000_BEEF);
    access(1'b1, 3'b001, 32'h0000_0011, 32'h1234_56AB, $urandom, 1, 1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0);
    access(1'b0, 3'b000, 32'h0000_0006, 32'h0, $urandom, 0, 1'b0, 4'h0, 32'h0, 32'h0);
    access(1'b1, 3'b011, 32'h0000_0001, $urandom, $urandom, 0, 1'b0, 4'h0, 32'h0, 32'h0);

    // abandon a load mid-BUSY with an ack pending
    idle();
    mem_ack = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'b000; req_addr = 32'h0000_0040;
    step();
    req_valid = 1'b0; mem_ack = 1'b0;
    e_ready = 1'b0; e_rv = 1'b0; e_mreq = 1'b1; e_mwe = 1'b0; e_mbe = 4'hF;
    e_maddr = 32'h0000_0040; e_mwd = 32'h0;
    step();
    #1;
    e_ready = 1'b1; e_rv = 1'b0; e_mreq = 1'b0; e_rdata = 32'h0; e_err = 2'b00;
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = $urandom;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 32'd0);
    chk("rst_async_req_ready", 32'(req_ready), 32'd1);
    step();
    reset = 1'b1; mem_ack = 1'b0;
    step();
    idle();
    step();
    idle();
    access(1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 4'hF, 32'h0, 32'hCAFE_F00D);

    for (int n = 0; n < 200; n++) begin
      r_we   = 1'($urandom);
      r_op   = 3'($urandom);
      r_addr = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      access(r_we, r_op, r_addr, r_wd, r_rd, int'($urandom_range(0, 5)), 1'b0, 4'h0, 32'h0, 32'h0);
      repeat ($urandom_range(0, 2)) begin
        step();
        idle();
      end
    end

`ifdef DM_TIMEOUT_EN
    access(1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h1234_5678, 20, 1'b1, 4'hF, 32'h0, 32'h0);
    access(1'b0, 3'b000, 32'h0000_0104, 32'h0, 32'h1234_5678, TO - 1, 1'b1, 4'hF, 32'h0, 32'h1234_5678);
`endif

    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
